countdown_timer: RTL and testbench

//   Hours/minutes/seconds countdown timer. Counts down from a loaded time to 00:00:00, then

---
 rtl/countdown_timer.sv | 139 +++++++++++++
 tb/tb_countdown_timer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Hours/minutes/seconds countdown timer with load, start/stop and done pulse.
// Outputs are registered; state and time all advance on posedge clk.
module countdown_timer #(
  parameter int TICKS_PER_SEC = 1,
  parameter int MAX_HOURS     = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [5:0] set_hours,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  output logic [5:0] hours,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int PW =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PSC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [5:0] HMAX = 6'(MAX_HOURS);
  localparam logic [5:0] LAST = 6'd59;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] psc_q, psc_d;
  logic [5:0]    hours_q, hours_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic set_ok;
  logic time_zero;
  logic last_sec;

  assign set_ok = (set_hours <= HMAX) &&
                  (set_min <= LAST) &&
                  (set_sec <= LAST);
  assign time_zero = (hours_q == 6'd0) &&
                     (min_q == 6'd0) &&
                     (sec_q == 6'd0);
  // RUN is only entered with a nonzero time, so 0:00:01 is the last tick
  assign last_sec = (hours_q == 6'd0) &&
                    (min_q == 6'd0) &&
                    (sec_q == 6'd1);

  always_comb begin
    state_d = state_q;
    psc_d   = psc_q;
    hours_d = hours_q;
    min_d   = min_q;
    sec_d   = sec_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      if (set_ok) begin
        hours_d = set_hours;
        min_d   = set_min;
        sec_d   = set_sec;
        psc_d   = '0;
        state_d = S_IDLE;
      end else begin
        err_d = 1'b1;
      end
    end else if (stop) begin
      if (state_q == S_RUN) state_d = S_HOLD;
    end else if (state_q == S_RUN) begin
      if (psc_q == PSC_MAX) begin
        psc_d = '0;
        if (sec_q != 6'd0) begin
          sec_d = sec_q - 6'd1;
        end else if (min_q != 6'd0) begin
          min_d = min_q - 6'd1;
          sec_d = LAST;
        end else if (hours_q != 6'd0) begin
          hours_d = hours_q - 6'd1;
          min_d   = LAST;
          sec_d   = LAST;
        end
        if (last_sec) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end else begin
        psc_d = psc_q + PW'(1);
      end
    end else if (start) begin
      if (state_q == S_HOLD) begin
        state_d = S_RUN;
      end else if (!time_zero) begin
        state_d = S_RUN;
        psc_d   = '0;
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      psc_q   <= '0;
      hours_q <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      hours_q <= hours_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign hours = hours_q;
  assign min   = min_q;
  assign sec   = sec_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: one instance at one tick per
// second, one at four ticks per second.
module tb_countdown_timer;

  typedef struct packed {
    logic [5:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       busy;
    logic       done;
    logic       err;
  } snap_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       load1, start1, stop1;
  logic       load4, start4, stop4;
  logic [5:0] set_hours, set_min, set_sec;
  logic [5:0] h1, m1, s1, h4, m4, s4;
  logic       busy1, done1, err1;
  logic       busy4, done4, err4;

  int n_chk = 0;
  int n_fail = 0;
  snap_t sb_q[$];

  always #5 clk = ~clk;

  countdown_timer #(.TICKS_PER_SEC(1), .MAX_HOURS(23)) u_t1 (
    .clk(clk), .reset(reset),
    .load(load1), .start(start1), .stop(stop1),
    .set_hours(set_hours), .set_min(set_min), .set_sec(set_sec),
    .hours(h1), .min(m1), .sec(s1),
    .busy(busy1), .done(done1), .err(err1)
  );

  countdown_timer #(.TICKS_PER_SEC(4), .MAX_HOURS(23)) u_t4 (
    .clk(clk), .reset(reset),
    .load(load4), .start(start4), .stop(stop4),
    .set_hours(set_hours), .set_min(set_min), .set_sec(set_sec),
    .hours(h4), .min(m4), .sec(s4),
    .busy(busy4), .done(done4), .err(err4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic snap_t mk(input int h, input int m, input int s,
                               input bit b, input bit d, input bit e);
    snap_t r;
    r.h = 6'(h);
    r.m = 6'(m);
    r.s = 6'(s);
    r.busy = b;
    r.done = d;
    r.err = e;
    return r;
  endfunction

  // sel: 0 = tick-1 unit, 1 = tick-4 unit, 2 = both
  task automatic step(input string tag, input int sel, input snap_t e);
    snap_t exp_v;
    snap_t g1;
    snap_t g4;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    exp_v = sb_q.pop_front();
    g1 = {h1, m1, s1, busy1, done1, err1};
    g4 = {h4, m4, s4, busy4, done4, err4};
    if (sel != 1) chk({tag, "/t1"}, 32'(g1), 32'(exp_v));
    if (sel != 0) chk({tag, "/t4"}, 32'(g4), 32'(exp_v));
  endtask

  task automatic set_t(input int h, input int m, input int s);
    set_hours = 6'(h);
    set_min = 6'(m);
    set_sec = 6'(s);
  endtask

  initial begin
    reset = 1'b0;
    {load1, start1, stop1, load4, start4, stop4} = '0;
    set_t(0, 0, 0);

    // reset dominates random loads and starts
    for (int i = 0; i < 3; i++) begin
      set_t($urandom_range(23), $urandom_range(59), $urandom_range(59));
      load1 = 1'b1;
      load4 = 1'b1;
      start1 = i[0];
      step("reset", 2, mk(0, 0, 0, 0, 0, 0));
    end
    reset = 1'b1;
    {load1, start1, load4} = '0;

    // three-second countdown
    set_t(0, 0, 3);
    load1 = 1'b1;
    step("ld3", 0, mk(0, 0, 3, 0, 0, 0));
    load1 = 1'b0;
    start1 = 1'b1;
    step("go3", 0, mk(0, 0, 3, 1, 0, 0));
    start1 = 1'b0;
    step("s2", 0, mk(0, 0, 2, 1, 0, 0));
    step("s1", 0, mk(0, 0, 1, 1, 0, 0));
    step("s0done", 0, mk(0, 0, 0, 0, 1, 0));
    step("idle0", 0, mk(0, 0, 0, 0, 0, 0));

    // hour and minute borrows
    set_t(1, 0, 0);
    load1 = 1'b1;
    step("ld1h", 0, mk(1, 0, 0, 0, 0, 0));
    load1 = 1'b0;
    start1 = 1'b1;
    step("go1h", 0, mk(1, 0, 0, 1, 0, 0));
    start1 = 1'b0;
    step("hborrow", 0, mk(0, 59, 59, 1, 0, 0));
    set_t(0, 1, 0);
    load1 = 1'b1;
    step("ldrun", 0, mk(0, 1, 0, 0, 0, 0));
    load1 = 1'b0;
    start1 = 1'b1;
    step("go1m", 0, mk(0, 1, 0, 1, 0, 0));
    start1 = 1'b0;
    step("mborrow", 0, mk(0, 0, 59, 1, 0, 0));

    // invalid loads while held at 0:05:07
    set_t(0, 5, 7);
    load1 = 1'b1;
    step("ld507", 0, mk(0, 5, 7, 0, 0, 0));
    load1 = 1'b0;
    start1 = 1'b1;
    step("go507", 0, mk(0, 5, 7, 1, 0, 0));
    start1 = 1'b0;
    stop1 = 1'b1;
    step("stopwin", 0, mk(0, 5, 7, 1, 0, 0));
    stop1 = 1'b0;
    set_t(0, 60, 0);
    load1 = 1'b1;
    step("errmin", 0, mk(0, 5, 7, 1, 0, 1));
    set_t(24, 0, 0);
    step("errhr", 0, mk(0, 5, 7, 1, 0, 1));
    load1 = 1'b0;
    step("errclr", 0, mk(0, 5, 7, 1, 0, 0));
    start1 = 1'b1;
    step("resume", 0, mk(0, 5, 7, 1, 0, 0));
    start1 = 1'b0;
    step("s506", 0, mk(0, 5, 6, 1, 0, 0));

    // boundary loads and start at zero
    set_t(23, 59, 59);
    load1 = 1'b1;
    step("ldmax", 0, mk(23, 59, 59, 0, 0, 0));
    set_t(0, 0, 0);
    step("ldzero", 0, mk(0, 0, 0, 0, 0, 0));
    load1 = 1'b0;
    start1 = 1'b1;
    step("gozero", 0, mk(0, 0, 0, 0, 0, 0));
    start1 = 1'b0;

    // reset mid-run, then load with start
    set_t(0, 0, 6);
    load1 = 1'b1;
    step("ld6", 0, mk(0, 0, 6, 0, 0, 0));
    load1 = 1'b0;
    start1 = 1'b1;
    step("go6", 0, mk(0, 0, 6, 1, 0, 0));
    start1 = 1'b0;
    step("s5", 0, mk(0, 0, 5, 1, 0, 0));
    reset = 1'b0;
    step("midrst", 0, mk(0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    set_t(0, 0, 4);
    load1 = 1'b1;
    start1 = 1'b1;
    step("ldstart", 0, mk(0, 0, 4, 0, 0, 0));
    load1 = 1'b0;
    start1 = 1'b0;
    step("staysidle", 0, mk(0, 0, 4, 0, 0, 0));

    // four ticks per second: pause and resume keep the prescaler
    set_t(0, 0, 2);
    load4 = 1'b1;
    step("t4ld", 1, mk(0, 0, 2, 0, 0, 0));
    load4 = 1'b0;
    start4 = 1'b1;
    step("t4go", 1, mk(0, 0, 2, 1, 0, 0));
    start4 = 1'b0;
    step("t4p1", 1, mk(0, 0, 2, 1, 0, 0));
    step("t4p2", 1, mk(0, 0, 2, 1, 0, 0));
    stop4 = 1'b1;
    step("t4stop", 1, mk(0, 0, 2, 1, 0, 0));
    stop4 = 1'b0;
    for (int i = 0; i < 10; i++)
      step("t4hold", 1, mk(0, 0, 2, 1, 0, 0));
    start4 = 1'b1;
    step("t4res", 1, mk(0, 0, 2, 1, 0, 0));
    start4 = 1'b0;
    step("t4r1", 1, mk(0, 0, 2, 1, 0, 0));
    step("t4dec", 1, mk(0, 0, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      step("t4wait", 1, mk(0, 0, 1, 1, 0, 0));
    step("t4done", 1, mk(0, 0, 0, 0, 1, 0));
    step("t4idle", 1, mk(0, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
